shadow_chain_collector: RTL and testbench

Root-level receiver for the shadow-capture dump chains. It sits above the topmost `shadow_capture` in the hierarchy and drives that block's `dump_en`. It samples the serial bits arriving on its chains, deserializes each chain into words tagged with the chain index and the number of valid bits, and hands those words to host-side logic through a FIFO with a valid/ready handshake. It stalls the chains when that FIFO cannot drain, and it signals completion once every chain has reported done.

---
 rtl/shadow_chain_collector.sv | 241 ++++++++++++++++++++++++
 tb/tb_shadow_chain_collector.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_chain_collector.sv
// shadow_chain_collector: root receiver for the shadow-capture dump chains.
// Deserializes each serial chain into tagged words, arbitrates the per-chain
// holding registers round-robin into a show-ahead FIFO, and stalls a chain
// while its holding register is occupied.
module shadow_chain_collector #(
  parameter int CHAINS        = 1,
  parameter int WORD_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int COUNTER_WIDTH = 12,
  localparam int ID_W = (CHAINS > 1) ? $clog2(CHAINS) : 1,
  localparam int NB_W = $clog2(WORD_WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CHAINS-1:0]        chains_in,
  input  logic [CHAINS-1:0]        chains_in_vld,
  input  logic [CHAINS-1:0]        chains_in_done,
  output logic [CHAINS-1:0]        dump_en,
  output logic                     busy,
  output logic                     done,
  output logic [COUNTER_WIDTH-1:0] bit_count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_WIDTH-1:0]    out_data,
  output logic [ID_W-1:0]          out_chain,
  output logic [NB_W-1:0]          out_bits
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {IDLE, DUMP} state_t;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic [ID_W-1:0]       chain;
    logic [NB_W-1:0]       nb;
  } entry_t;

  state_t state_q, state_d;

  logic [WORD_WIDTH-1:0]    sr_q [CHAINS];
  logic [WORD_WIDTH-1:0]    sr_d [CHAINS];
  logic [WORD_WIDTH-1:0]    sr_ins [CHAINS];
  logic [NB_W-1:0]          cnt_q [CHAINS];
  logic [NB_W-1:0]          cnt_d [CHAINS];
  logic [WORD_WIDTH-1:0]    hold_data_q [CHAINS];
  logic [WORD_WIDTH-1:0]    hold_data_d [CHAINS];
  logic [NB_W-1:0]          hold_nb_q [CHAINS];
  logic [NB_W-1:0]          hold_nb_d [CHAINS];
  logic [CHAINS-1:0]        hold_vld_q, hold_vld_d;
  logic [CHAINS-1:0]        done_seen_q, done_seen_d;
  logic [CHAINS-1:0]        cnt_nonzero;
  logic [ID_W-1:0]          rr_q, rr_d;
  logic [COUNTER_WIDTH-1:0] bit_count_q, bit_count_d;

  entry_t                   mem_q [FIFO_DEPTH];
  entry_t                   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [OCC_W-1:0]         occ_q, occ_d;

  logic                     grant_vld;
  logic [ID_W-1:0]          grant_idx;
  logic                     push, pop;
  logic                     all_clear;
  logic [COUNTER_WIDTH:0]   bit_sum;
  int                       n_acc;

  // State register for the IDLE/DUMP controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Dump finishes once every chain reported done and nothing is left in flight.
  always_comb begin
    for (int c = 0; c < CHAINS; c++) cnt_nonzero[c] = (cnt_q[c] != '0);
    all_clear = (&done_seen_q) & ~(|cnt_nonzero) & ~(|hold_vld_q);
  end

  // Next-state logic: start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = DUMP;
      DUMP:    if (all_clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller outputs; a chain shifts only while its hold register is free.
  always_comb begin
    busy    = (state_q == DUMP);
    done    = 1'b0;
    dump_en = '0;
    if (state_q == DUMP) begin
      dump_en = ~done_seen_q & ~hold_vld_q;
      done    = all_clear;
    end
  end

  // Current shift register with the incoming bit ORed in at position cnt.
  always_comb begin
    for (int c = 0; c < CHAINS; c++)
      sr_ins[c] = sr_q[c] | (WORD_WIDTH'(chains_in[c]) << cnt_q[c]);
  end

  // Round-robin pick of the first occupied hold register at or after rr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < CHAINS; k++) begin
      if (!grant_vld && hold_vld_q[(int'(rr_q) + k) % CHAINS]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'((int'(rr_q) + k) % CHAINS);
      end
    end
  end

  assign push = grant_vld & (occ_q != OCC_W'(FIFO_DEPTH));
  assign pop  = (occ_q != '0) & out_ready;

  // Per-chain deserializer, done tracking, partial flush and bit counting.
  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    hold_data_d = hold_data_q;
    hold_nb_d   = hold_nb_q;
    hold_vld_d  = hold_vld_q;
    done_seen_d = done_seen_q;
    rr_d        = rr_q;
    bit_count_d = bit_count_q;
    n_acc       = 0;
    bit_sum     = '0;
    if (state_q == IDLE && start) begin
      for (int c = 0; c < CHAINS; c++) begin
        sr_d[c]  = '0;
        cnt_d[c] = '0;
      end
      done_seen_d = '0;
      bit_count_d = '0;
      rr_d        = '0;
    end else if (state_q == DUMP) begin
      for (int c = 0; c < CHAINS; c++) begin
        if (dump_en[c] && chains_in_vld[c]) begin
          n_acc = n_acc + 1;
          if (cnt_q[c] == NB_W'(WORD_WIDTH - 1)) begin
            hold_data_d[c] = sr_ins[c];
            hold_nb_d[c]   = NB_W'(WORD_WIDTH);
            hold_vld_d[c]  = 1'b1;
            cnt_d[c]       = '0;
            sr_d[c]        = '0;
          end else begin
            sr_d[c]  = sr_ins[c];
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
        end else if (done_seen_q[c] && cnt_nonzero[c] && !hold_vld_q[c]) begin
          hold_data_d[c] = sr_q[c];
          hold_nb_d[c]   = cnt_q[c];
          hold_vld_d[c]  = 1'b1;
          cnt_d[c]       = '0;
          sr_d[c]        = '0;
        end
        if (chains_in_done[c]) done_seen_d[c] = 1'b1;
      end
      bit_sum = {1'b0, bit_count_q} + (COUNTER_WIDTH + 1)'(n_acc);
      bit_count_d = bit_sum[COUNTER_WIDTH] ? '1 : bit_sum[COUNTER_WIDTH-1:0];
    end
    if (push) begin
      hold_vld_d[grant_idx] = 1'b0;
      rr_d = (grant_idx == ID_W'(CHAINS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Per-chain registers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHAINS; c++) begin
        sr_q[c]        <= '0;
        cnt_q[c]       <= '0;
        hold_data_q[c] <= '0;
        hold_nb_q[c]   <= '0;
      end
      hold_vld_q  <= '0;
      done_seen_q <= '0;
      rr_q        <= '0;
      bit_count_q <= '0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      hold_data_q <= hold_data_d;
      hold_nb_q   <= hold_nb_d;
      hold_vld_q  <= hold_vld_d;
      done_seen_q <= done_seen_d;
      rr_q        <= rr_d;
      bit_count_q <= bit_count_d;
    end
  end

  // FIFO pointer and storage update; runs regardless of controller state.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (push) begin
      mem_d[wr_q] = '{data: hold_data_q[grant_idx], chain: grant_idx,
                      nb: hold_nb_q[grant_idx]};
      wr_d = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
  end

  // FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // Show-ahead head presentation, forced to zero while the FIFO is empty.
  always_comb begin
    out_valid = (occ_q != '0);
    out_data  = out_valid ? mem_q[rd_q].data  : '0;
    out_chain = out_valid ? mem_q[rd_q].chain : '0;
    out_bits  = out_valid ? mem_q[rd_q].nb    : '0;
  end

  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_shadow_chain_collector.sv
// Directed testbench for shadow_chain_collector (2 chains, 8-bit words, 4-deep FIFO).
module tb_shadow_chain_collector;

  localparam int CH  = 2;
  localparam int WW  = 8;
  localparam int FD  = 4;
  localparam int CW  = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CH-1:0] chains_in, chains_in_vld, chains_in_done;
  logic [CH-1:0] dump_en;
  logic          busy, done;
  logic [CW-1:0] bit_count;
  logic          out_valid, out_ready;
  logic [WW-1:0] out_data;
  logic [0:0]    out_chain;
  logic [3:0]    out_bits;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [0:0] chain;
    logic [3:0] nb;
    logic [7:0] data;
  } ent_t;

  typedef struct {
    logic [15:0]      bits;
    int               nbits;
    int               exp_n;
    logic [1:0][7:0]  exp_data;
    logic [1:0][3:0]  exp_nb;
    int               exp_count;
  } vec_t;

  ent_t got[$];
  ent_t expq[$];
  vec_t tbl[5];

  shadow_chain_collector #(
    .CHAINS(CH), .WORD_WIDTH(WW), .FIFO_DEPTH(FD), .COUNTER_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .chains_in(chains_in), .chains_in_vld(chains_in_vld),
    .chains_in_done(chains_in_done), .dump_en(dump_en),
    .busy(busy), .done(done), .bit_count(bit_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chain(out_chain), .out_bits(out_bits)
  );

  always #5 clk = ~clk;

  // Record every popped head entry; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back({out_chain, out_bits, out_data});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input int ch, input logic b);
    int guard = 0;
    while (!dump_en[ch] && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) begin
      total++;
      bad++;
      $display("[TB] FAIL send_timeout: got dump_en=%0b expected 1 on chain %0d", dump_en, ch);
    end
    chains_in[ch]     = b;
    chains_in_vld[ch] = 1'b1;
    tick();
    chains_in_vld[ch] = 1'b0;
  endtask

  task automatic send_pair(input logic b0, input logic b1);
    int guard = 0;
    while (dump_en != 2'b11 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) begin
      total++;
      bad++;
      $display("[TB] FAIL pair_timeout: got dump_en=%0b expected 11", dump_en);
    end
    chains_in     = {b1, b0};
    chains_in_vld = 2'b11;
    tick();
    chains_in_vld = 2'b00;
  endtask

  task automatic start_dump;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Raise done on both chains and expect exactly one completion pulse.
  task automatic finish_dump(input string tag);
    int pulses = 0;
    chains_in_done = 2'b11;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    check({tag, "_done_pulses"}, pulses, 1);
    check({tag, "_busy_after"}, busy, 0);
    chains_in_done = 2'b00;
  endtask

  task automatic check_entries(input string tag);
    check({tag, "_entry_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      check($sformatf("%s_e%0d_data", tag, i), got[i].data, expq[i].data);
      check($sformatf("%s_e%0d_bits", tag, i), got[i].nb, expq[i].nb);
      check($sformatf("%s_e%0d_chain", tag, i), got[i].chain, expq[i].chain);
    end
    got.delete();
    expq.delete();
  endtask

  logic [7:0] bp_words [6];
  logic [5:0] sd_bits;

  initial begin
    tbl[0] = '{16'h3CA5, 16, 2, {8'h3C, 8'hA5}, {4'd8, 4'd8}, 16};
    tbl[1] = '{16'h05FF, 11, 2, {8'h05, 8'hFF}, {4'd3, 4'd8}, 11};
    tbl[2] = '{16'h0000,  0, 0, {8'h00, 8'h00}, {4'd0, 4'd0},  0};
    tbl[3] = '{16'h0016,  5, 1, {8'h00, 8'h16}, {4'd0, 4'd5},  5};
    tbl[4] = '{16'h0081,  8, 1, {8'h00, 8'h81}, {4'd0, 4'd8},  8};
    bp_words = '{8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h96, 8'h7E};

    rst_n = 1'b0;
    start = 1'b0;
    chains_in = '0;
    chains_in_vld = '0;
    chains_in_done = '0;
    out_ready = 1'b0;
    #3;
    check("rst_dump_en", dump_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_bit_count", bit_count, 0);
    check("rst_out_data", out_data, 0);
    #19 rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Single-chain dumps on chain 0; chain 1 reports done immediately.
    for (int i = 0; i < 5; i++) begin
      got.delete();
      chains_in_done = 2'b10;
      out_ready = 1'b1;
      start_dump();
      check($sformatf("t%0d_busy", i), busy, 1);
      for (int b = 0; b < tbl[i].nbits; b++) send_bit(0, tbl[i].bits[b]);
      finish_dump($sformatf("t%0d", i));
      check($sformatf("t%0d_bit_count", i), bit_count, tbl[i].exp_count);
      for (int k = 0; k < tbl[i].exp_n; k++)
        expq.push_back({1'b0, tbl[i].exp_nb[k], tbl[i].exp_data[k]});
      check_entries($sformatf("t%0d", i));
    end

    // Both chains complete a word at the same edge, twice.
    out_ready = 1'b1;
    start_dump();
    for (int b = 0; b < 8; b++) send_pair(b == 0 || b == 4, b == 1 || b == 5);
    check("tie1_en_e", dump_en, 2'b00);
    tick();
    check("tie1_en_e1", dump_en, 2'b01);
    tick();
    check("tie1_en_e2", dump_en, 2'b11);
    for (int b = 0; b < 8; b++) send_pair(b == 0 || b == 1 || b == 4 || b == 5, b == 2 || b == 6);
    check("tie2_en_e", dump_en, 2'b00);
    tick();
    check("tie2_en_e1", dump_en, 2'b01);
    finish_dump("tie");
    check("tie_bit_count", bit_count, 32);
    expq.push_back({1'b0, 4'd8, 8'h11});
    expq.push_back({1'b1, 4'd8, 8'h22});
    expq.push_back({1'b0, 4'd8, 8'h33});
    expq.push_back({1'b1, 4'd8, 8'h44});
    check_entries("tie");

    // Backpressure: 4 words fill the FIFO, the 5th sits in the hold register.
    out_ready = 1'b0;
    chains_in_done = 2'b10;
    start_dump();
    for (int w = 0; w < 5; w++)
      for (int b = 0; b < 8; b++) send_bit(0, bp_words[w][b]);
    repeat (6) tick();
    check("bp_dump_en", dump_en[0], 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head", out_data, bp_words[0]);
    check("bp_no_pops", got.size(), 0);
    check("bp_bit_count", bit_count, 40);
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) send_bit(0, bp_words[5][b]);
    finish_dump("bp");
    check("bp_bit_count_end", bit_count, 48);
    for (int w = 0; w < 6; w++) expq.push_back({1'b0, 4'd8, bp_words[w]});
    check_entries("bp");

    // Start during DUMP is ignored; done with a valid bit keeps that bit.
    out_ready = 1'b1;
    chains_in_done = 2'b10;
    start_dump();
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    start_dump();
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    sd_bits = 6'b111011;
    chains_in[0] = sd_bits[5];
    chains_in_vld[0] = 1'b1;
    chains_in_done[0] = 1'b1;
    tick();
    chains_in_vld[0] = 1'b0;
    finish_dump("sd");
    check("sd_bit_count", bit_count, 6);
    expq.push_back({1'b0, 4'd6, 8'h3B});
    check_entries("sd");

    // Asynchronous reset in the middle of a word with the FIFO non-empty.
    out_ready = 1'b0;
    chains_in_done = 2'b10;
    start_dump();
    for (int b = 0; b < 11; b++) send_bit(0, 1'b1);
    tick();
    check("mid_busy_pre", busy, 1);
    check("mid_en_pre", dump_en[0], 1);
    check("mid_valid_pre", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_dump_en", dump_en, 0);
    check("mid_busy", busy, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_bit_count", bit_count, 0);
    #2 rst_n = 1'b1;
    chains_in_done = 2'b00;
    repeat (3) tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_dump_en", dump_en, 0);
    got.delete();

    // Recovery after reset: a fresh dump still works.
    out_ready = 1'b1;
    chains_in_done = 2'b10;
    start_dump();
    for (int b = 0; b < 8; b++) send_bit(0, b[0]);
    finish_dump("rec");
    expq.push_back({1'b0, 4'd8, 8'hAA});
    check_entries("rec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
